// File: rtl/dp_seq_pkg.sv
// Shared opcodes, instruction field positions, FSM states and decode classes for dp_sequencer.
// Includes the opcode reserved for the optional BNZ instruction, which is enabled by BRANCH_NZ_EN.
package dp_seq_pkg;

  localparam logic [3:0] OPC_LDI  = 4'h8;
  localparam logic [3:0] OPC_LD   = 4'h9;
  localparam logic [3:0] OPC_ST   = 4'hA;
  localparam logic [3:0] OPC_BZ   = 4'hB;
  localparam logic [3:0] OPC_JMP  = 4'hC;
  localparam logic [3:0] OPC_HALT = 4'hD;
  localparam logic [3:0] OPC_BNZ  = 4'hE;

  localparam logic [3:0] OP_PASSB = 4'h8;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 8;
  localparam int RA_MSB   = 7;
  localparam int RA_LSB   = 4;
  localparam int RB_MSB   = 3;
  localparam int RB_LSB   = 0;
  localparam int BOFF_MSB = 7;
  localparam int JMP_MSB  = 11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_EXEC, ST_IMM, ST_IMMWB, ST_MEM, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU, CL_LDI, CL_LD, CL_ST, CL_BZ, CL_BNZ, CL_JMP, CL_HALT
  } iclass_e;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    sext8 = {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/dp_seq_decode.sv
// Combinational instruction decoder: maps ir to class, register fields, ALU op, branch offset and jump target.
// Zero latency. Opcode 0xE decodes as BNZ only when BRANCH_NZ_EN is defined; otherwise it is illegal.
module dp_seq_decode
  import dp_seq_pkg::*;
(
  input  logic [15:0] ir_i,
  output iclass_e     cls_o,
  output logic [3:0]  rd_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [3:0]  op_sel_o,
  output logic [15:0] br_off_o,
  output logic [15:0] jmp_tgt_o,
  output logic        illegal_o
);

  logic [3:0] opc;

  assign opc       = ir_i[OPC_MSB:OPC_LSB];
  assign rd_o      = ir_i[RD_MSB:RD_LSB];
  assign ra_o      = ir_i[RA_MSB:RA_LSB];
  assign rb_o      = ir_i[RB_MSB:RB_LSB];
  assign op_sel_o  = {1'b0, opc[2:0]};
  assign br_off_o  = sext8(ir_i[BOFF_MSB:0]);
  assign jmp_tgt_o = {4'h0, ir_i[JMP_MSB:0]};

  always_comb begin
    cls_o     = CL_HALT;
    illegal_o = 1'b0;
    if (!opc[3]) begin
      cls_o = CL_ALU;
    end else begin
      case (opc)
        OPC_LDI:  cls_o = CL_LDI;
        OPC_LD:   cls_o = CL_LD;
        OPC_ST:   cls_o = CL_ST;
        OPC_BZ:   cls_o = CL_BZ;
        OPC_JMP:  cls_o = CL_JMP;
        OPC_HALT: cls_o = CL_HALT;
`ifdef BRANCH_NZ_EN
        OPC_BNZ:  cls_o = CL_BNZ;
`endif
        default:  illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle fetch/decode/execute controller for a 16-register datapath behind a single-port memory.
// Memory transfers stall on mem_ack; BNZ on opcode 0xE is enabled by BRANCH_NZ_EN.
module dp_sequencer
  import dp_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic [15:0] a_out,
  input  logic [15:0] b_out,
  input  logic        z,
  output logic [3:0]  a_sel,
  output logic [3:0]  b_sel,
  output logic [3:0]  dest_sel,
  output logic [3:0]  op_sel,
  output logic [15:0] const_in,
  output logic        const_sel,
  output logic        data_sel,
  output logic        load_en,
  output logic [15:0] pc,
  output logic        halted,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d, imm_q, imm_d;
  logic        zflag_q, zflag_d, zcap_q, zcap_d, illegal_q, illegal_d;

  iclass_e     dec_cls;
  logic [3:0]  dec_rd, dec_ra, dec_rb, dec_op;
  logic [15:0] dec_off, dec_tgt;
  logic        dec_ill;

  dp_seq_decode u_dec (
    .ir_i      (ir_q),
    .cls_o     (dec_cls),
    .rd_o      (dec_rd),
    .ra_o      (dec_ra),
    .rb_o      (dec_rb),
    .op_sel_o  (dec_op),
    .br_off_o  (dec_off),
    .jmp_tgt_o (dec_tgt),
    .illegal_o (dec_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      imm_q     <= 16'h0000;
      zflag_q   <= 1'b0;
      zcap_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      zflag_q   <= zflag_d;
      zcap_q    <= zcap_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    illegal_d = illegal_q;
    zcap_d    = 1'b0;
    // The datapath z register lags its write by one cycle, so sample it the cycle after.
    zflag_d   = zcap_q ? z : zflag_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    a_sel     = 4'h0;
    b_sel     = 4'h0;
    dest_sel  = 4'h0;
    op_sel    = 4'h0;
    const_in  = 16'h0000;
    const_sel = 1'b0;
    data_sel  = 1'b0;
    load_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH, ST_IMM: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          pc_d = pc_q + 16'd1;
          if (state_q == ST_FETCH) begin
            ir_d    = mem_rdata;
            state_d = ST_EXEC;
          end else begin
            imm_d   = mem_rdata;
            state_d = ST_IMMWB;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (dec_cls)
          CL_ALU: begin
            a_sel    = dec_ra;
            b_sel    = dec_rb;
            dest_sel = dec_rd;
            op_sel   = dec_op;
            load_en  = 1'b1;
            zcap_d   = 1'b1;
          end
          CL_LDI:  state_d = ST_IMM;
          CL_LD,
          CL_ST:   state_d = ST_MEM;
          CL_BZ:   if (zflag_q) pc_d = pc_q + dec_off;
          CL_BNZ:  if (!zflag_q) pc_d = pc_q + dec_off;
          CL_JMP:  pc_d = dec_tgt;
          default: begin
            illegal_d = dec_ill;
            state_d   = ST_HALT;
          end
        endcase
      end
      ST_IMMWB: begin
        const_in  = imm_q;
        const_sel = 1'b1;
        op_sel    = OP_PASSB;
        dest_sel  = dec_rd;
        load_en   = 1'b1;
        zcap_d    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEM: begin
        a_sel    = dec_ra;
        b_sel    = dec_rb;
        mem_req  = 1'b1;
        mem_addr = a_out;
        if (dec_cls == CL_ST) begin
          mem_we    = 1'b1;
          mem_wdata = b_out;
        end
        if (mem_ack) begin
          if (dec_cls == CL_LD) begin
            data_sel = 1'b1;
            dest_sel = dec_rd;
            load_en  = 1'b1;
          end
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (start) begin
          illegal_d = 1'b0;
          pc_d      = RESET_PC;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pc      = pc_q;
  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;

endmodule
